// File: rtl/io_write_port_ctrl_pkg.sv
// io_write_port_ctrl_pkg: shared constants, port-state encoding and default widths for the I/O write-port controller.
package io_write_port_ctrl_pkg;
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam int DEF_PORT_COUNT = 4;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_WORD_WIDTH = 36;
endpackage

// File: rtl/io_write_port_slot.sv
// io_write_port_slot: one write port holding a data word, its write strobe and its full flag.
module io_write_port_slot
    import io_write_port_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  accept,
    input  logic                  ack,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  wren,
    output logic [WORD_WIDTH-1:0] q,
    output logic                  full,
    output logic                  eff_full
);
    // An ack in the commit cycle frees the slot for a write in that same cycle.
    assign eff_full = full & ~ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wren <= LOW;
            q    <= '0;
            full <= EMPTY;
        end else begin
            wren <= accept;
            if (accept) q <= data;
            full <= accept ? FULL : (ack ? EMPTY : full);
        end
    end
endmodule

// File: rtl/io_write_port_ctrl.sv
// io_write_port_ctrl: steers I/O-range data writes to per-port registers and flags writes to full ports as blocked.
// Optional blocked-write counter enabled by IO_WRITE_PORT_CTRL_STALL_COUNT_EN.
module io_write_port_ctrl
    import io_write_port_ctrl_pkg::*;
#(
    parameter int IO_WRITE_PORT_COUNT      = DEF_PORT_COUNT,
    parameter int IO_WRITE_PORT_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH               = DEF_WORD_WIDTH,
    parameter int STALL_COUNT_WIDTH        = 16
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      addr_in_io_range,
    input  logic                                      write_valid,
    input  logic [IO_WRITE_PORT_ADDR_WIDTH-1:0]       port_addr,
    input  logic [WORD_WIDTH-1:0]                     write_data,
    input  logic [IO_WRITE_PORT_COUNT-1:0]            port_ack,
    output logic [IO_WRITE_PORT_COUNT-1:0]            wren,
    output logic [IO_WRITE_PORT_COUNT*WORD_WIDTH-1:0] port_data,
    output logic [IO_WRITE_PORT_COUNT-1:0]            port_full,
    output logic                                      write_blocked,
    output logic [STALL_COUNT_WIDTH-1:0]              stall_count
);
    logic                                req_valid;
    logic [IO_WRITE_PORT_ADDR_WIDTH-1:0] req_port;
    logic [WORD_WIDTH-1:0]               req_data;
    logic [IO_WRITE_PORT_COUNT-1:0]      hit;
    logic [IO_WRITE_PORT_COUNT-1:0]      accept;
    logic [IO_WRITE_PORT_COUNT-1:0]      eff_full;

    // Out-of-range port indices never become a valid request, so they are dropped without blocking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_valid <= LOW;
            req_port  <= '0;
            req_data  <= '0;
        end else begin
            req_valid <= addr_in_io_range & write_valid & (int'(port_addr) < IO_WRITE_PORT_COUNT);
            req_port  <= port_addr;
            req_data  <= write_data;
        end
    end

    for (genvar p = 0; p < IO_WRITE_PORT_COUNT; p++) begin : g_slot
        assign hit[p]    = req_valid & (req_port == IO_WRITE_PORT_ADDR_WIDTH'(p));
        assign accept[p] = hit[p] & ~eff_full[p];
        io_write_port_slot #(.WORD_WIDTH(WORD_WIDTH)) u_slot (
            .clock    (clock),
            .reset_n  (reset_n),
            .accept   (accept[p]),
            .ack      (port_ack[p]),
            .data     (req_data),
            .wren     (wren[p]),
            .q        (port_data[p*WORD_WIDTH +: WORD_WIDTH]),
            .full     (port_full[p]),
            .eff_full (eff_full[p])
        );
    end

    assign write_blocked = |(hit & eff_full);

`ifdef IO_WRITE_PORT_CTRL_STALL_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_count <= '0;
        else if (write_blocked && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_io_write_port_ctrl.sv
// tb_io_write_port_ctrl: directed checks of the I/O write-port controller (4-port and 3-port/2-bit-counter instances).
module tb_io_write_port_ctrl;
    localparam int W = 36;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         air = 1'b0, wv = 1'b0;
    logic [1:0]   pa = '0;
    logic [W-1:0] wd = '0;
    logic [3:0]   ack = '0;
    logic [3:0]   wren;
    logic [4*W-1:0] pdata;
    logic [3:0]   full;
    logic         blk;
    logic [15:0]  sc;

    logic         v1 = 1'b0;
    logic [1:0]   pa1 = '0;
    logic [W-1:0] wd1 = '0;
    logic [2:0]   ack1 = '0;
    logic [2:0]   wren1;
    logic [3*W-1:0] pdata1;
    logic [2:0]   full1;
    logic         blk1;
    logic [1:0]   sc1;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;

    always #5 clock = ~clock;

    io_write_port_ctrl u0 (
        .clock(clock), .reset_n(reset_n), .addr_in_io_range(air), .write_valid(wv),
        .port_addr(pa), .write_data(wd), .port_ack(ack), .wren(wren), .port_data(pdata),
        .port_full(full), .write_blocked(blk), .stall_count(sc)
    );

    io_write_port_ctrl #(.IO_WRITE_PORT_COUNT(3), .IO_WRITE_PORT_ADDR_WIDTH(2),
                         .WORD_WIDTH(W), .STALL_COUNT_WIDTH(2)) u1 (
        .clock(clock), .reset_n(reset_n), .addr_in_io_range(1'b1), .write_valid(v1),
        .port_addr(pa1), .write_data(wd1), .port_ack(ack1), .wren(wren1), .port_data(pdata1),
        .port_full(full1), .write_blocked(blk1), .stall_count(sc1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sc_exp(input int n, input int maxv);
`ifdef IO_WRITE_PORT_CTRL_STALL_COUNT_EN
        return (n > maxv) ? maxv : n;
`else
        return 0 * n * maxv;
`endif
    endfunction

    initial begin
        tick(); tick();
        reset_n = 1'b1;
        tick();
        // Reset asserted while a registered request is in flight
        air = 1'b1; wv = 1'b1; pa = 2'd2; wd = 36'hABC;
        tick();
        wv = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_blocked", 144'(blk), 144'(0));
        chk("rst_full_async", 144'(full), 144'(0));
        tick();
        chk("rst_wren", 144'(wren), 144'(0));
        chk("rst_data", pdata, 144'(0));
        chk("rst_sc", 144'(sc), 144'(0));
        reset_n = 1'b1;
        tick();
        chk("rst_wren_after", 144'(wren), 144'(0));
        chk("rst_full_after", 144'(full), 144'(0));

        // Single write to port 2
        wv = 1'b1; pa = 2'd2; wd = 36'h123456789;
        tick();
        wv = 1'b0;
        chk("single_blocked", 144'(blk), 144'(0));
        chk("single_wren_early", 144'(wren), 144'(0));
        tick();
        chk("single_wren", 144'(wren), 144'(4'b0100));
        chk("single_data", 144'(pdata[2*W +: W]), 144'(36'h123456789));
        chk("single_full", 144'(full), 144'(4'b0100));
        tick();
        chk("single_wren_once", 144'(wren), 144'(0));
        chk("single_full_hold", 144'(full), 144'(4'b0100));

        // Fill port 1 and then write to it with no ack
        wv = 1'b1; pa = 2'd1; wd = 36'h11;
        tick(); wv = 1'b0; tick(); tick();
        chk("fill1_full", 144'(full), 144'(4'b0110));
        wv = 1'b1; pa = 2'd1; wd = 36'hAA;
        tick();
        wv = 1'b0;
        chk("full_blocked", 144'(blk), 144'(1));
        exp_sc++;
        tick();
        chk("full_wren", 144'(wren), 144'(0));
        chk("full_data", 144'(pdata[1*W +: W]), 144'(36'h11));
        chk("full_sc", 144'(sc), 144'(sc_exp(exp_sc, 65535)));
        chk("full_blocked_clear", 144'(blk), 144'(0));

        // Simultaneous ack and write on full port 0
        wv = 1'b1; pa = 2'd0; wd = 36'h77;
        tick(); wv = 1'b0; tick(); tick();
        chk("fill0_full", 144'(full), 144'(4'b0111));
        wv = 1'b1; pa = 2'd0; wd = 36'h55;
        tick();
        wv = 1'b0; ack = 4'b0001;
        #1;
        chk("ackwr_blocked", 144'(blk), 144'(0));
        tick();
        ack = 4'b0000;
        chk("ackwr_wren", 144'(wren), 144'(4'b0001));
        chk("ackwr_data", 144'(pdata[0 +: W]), 144'(36'h55));
        chk("ackwr_full", 144'(full), 144'(4'b0111));

        // Ack alone empties a port but keeps its data
        ack = 4'b0100;
        tick();
        ack = 4'b0000;
        chk("ack_full", 144'(full), 144'(4'b0011));
        chk("ack_data_hold", 144'(pdata[2*W +: W]), 144'(36'h123456789));
        chk("ack_wren", 144'(wren), 144'(0));

        // Back-to-back writes to distinct ports
        wv = 1'b1; pa = 2'd2; wd = 36'h222;
        tick();
        pa = 2'd3; wd = 36'h333;
        tick();
        wv = 1'b0;
        chk("b2b_wren_a", 144'(wren), 144'(4'b0100));
        tick();
        chk("b2b_wren_b", 144'(wren), 144'(4'b1000));
        chk("b2b_full", 144'(full), 144'(4'b1111));
        chk("b2b_data3", 144'(pdata[3*W +: W]), 144'(36'h333));

        // Back-to-back writes to the same empty port
        ack = 4'b0100;
        tick();
        ack = 4'b0000;
        wv = 1'b1; pa = 2'd2; wd = 36'hA0A;
        tick();
        wd = 36'hB0B;
        tick();
        wv = 1'b0;
        chk("same_wren", 144'(wren), 144'(4'b0100));
        chk("same_blocked", 144'(blk), 144'(1));
        exp_sc++;
        tick();
        chk("same_wren_none", 144'(wren), 144'(0));
        chk("same_data", 144'(pdata[2*W +: W]), 144'(36'hA0A));
        chk("same_sc", 144'(sc), 144'(sc_exp(exp_sc, 65535)));

        // Out-of-range index on the 3-port instance
        v1 = 1'b1; pa1 = 2'd3; wd1 = 36'h5;
        tick();
        v1 = 1'b0;
        chk("oor_blocked", 144'(blk1), 144'(0));
        tick();
        chk("oor_wren", 144'(wren1), 144'(0));
        chk("oor_full", 144'(full1), 144'(0));
        chk("oor_data", 144'(pdata1), 144'(0));
        chk("oor_sc", 144'(sc1), 144'(0));

        // 2-bit counter saturation with repeated blocked writes
        v1 = 1'b1; pa1 = 2'd0; wd1 = 36'h1;
        tick(); v1 = 1'b0; tick(); tick();
        chk("sat_fill", 144'(full1), 144'(3'b001));
        v1 = 1'b1; wd1 = 36'h2;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sat_blocked%0d", i), 144'(blk1), 144'(1));
            tick();
            chk($sformatf("sat_sc%0d", i), 144'(sc1), 144'(sc_exp(i + 1, 3)));
        end
        v1 = 1'b0;
        chk("sat_data", 144'(pdata1[0 +: W]), 144'(36'h1));
        tick(); tick();
        chk("sat_hold", 144'(sc1), 144'(sc_exp(6, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_write_port_ctrl.md
# io_write_port_ctrl

Write-side counterpart of the I/O read-enable logic. It takes data-memory writes that fall in the I/O address range and steers them to one of several I/O write ports. Each port has a data register, a one-cycle write-enable strobe, and a full flag that stays set until the external consumer acknowledges the word. Writes to a full port are reported back to the pipeline as blocked, so the instruction can be annulled and replayed.

## Interface
Parameters:
- IO_WRITE_PORT_COUNT, 4, number of write ports
- IO_WRITE_PORT_ADDR_WIDTH, 2, width of port index
- WORD_WIDTH, 36, data word width
- STALL_COUNT_WIDTH, 16, width of blocked-write counter

Ports:
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- addr_in_io_range  in  1  current write address decodes to I/O space
- write_valid  in  1  current instruction performs a data write
- port_addr  in  IO_WRITE_PORT_ADDR_WIDTH  target port index
- write_data  in  WORD_WIDTH  word to write
- port_ack  in  IO_WRITE_PORT_COUNT  per-port consumer acknowledge; the consumer has taken the word
- wren  out  IO_WRITE_PORT_COUNT  per-port one-cycle strobe: new word present
- port_data  out  IO_WRITE_PORT_COUNT*WORD_WIDTH  per-port held word; port p is at bits [p*WORD_WIDTH +: WORD_WIDTH]
- port_full  out  IO_WRITE_PORT_COUNT  per-port word held, not yet acknowledged
- write_blocked  out  1  registered request targets a full port; the pipeline annuls it
- stall_count  out  STALL_COUNT_WIDTH  saturating count of blocked writes

## Operation
- **Stage 1 (request register):**
  - req_valid <= addr_in_io_range & write_valid & (port_addr < IO_WRITE_PORT_COUNT).
  - req_port and req_data are loaded unconditionally.
  - Out-of-range indices are dropped silently. They are not reported as blocked.
- **Stage 2 (commit), combinational check on the registered request:**
  - eff_full[p] = port_full[p] & ~port_ack[p].
  - write_blocked = req_valid & eff_full[req_port].
  - Accepted (req_valid & ~eff_full[req_port]):
    - port_data[req_port] <= req_data
    - port_full[req_port] <= 1
    - wren[req_port] <= 1 for exactly one cycle
  - Blocked: no port state changes. The pipeline owns the replay.
- **Per-port full flag** (states EMPTY / FULL):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on port_ack when no accept hits that port in the same cycle.
  - FULL stays FULL on simultaneous ack and accept. The data is replaced and wren pulses.
  - port_ack while EMPTY is ignored.
- wren on all ports other than the accepted port is 0 every cycle. At most one wren bit is high per cycle.
- port_data holds its value while EMPTY. It is only overwritten on accept.

## Timing
- **Reset (asynchronous, immediate):**
  - wren = 0, port_full = 0, port_data = 0, write_blocked = 0, stall_count = 0.
  - req_valid = 0, so a request in flight is discarded.
- Request presented in cycle N is registered at the end of cycle N. write_blocked is valid during N+1.
- If accepted, wren, port_data and port_full update at the end of N+1 and are visible in N+2. Latency from request to strobe is 2 cycles.
- Back-to-back requests to the same empty port: the first is accepted and the second is blocked, unless port_ack arrives in the second request's commit cycle.
- Throughput: one write per cycle across distinct ports.
- port_ack is sampled in the commit cycle only. There is no ack buffering.

## Configuration
- Macro: IO_WRITE_PORT_CTRL_STALL_COUNT_EN.
- **Defined:**
  - stall_count increments by 1 at the end of every cycle in which write_blocked = 1.
  - It saturates at all-ones and never wraps.
  - It is cleared only by reset.
- **Undefined:** the counter logic is absent and stall_count is tied to 0. The port stays in the interface.

## Structure
- Shared package holds:
  - HIGH/LOW constants
  - the per-port state encoding (EMPTY = 0, FULL = 1)
  - default widths for port count, address width and word width
- One sub-module, io_write_port_slot, instantiated per port:
  - inputs: clock, reset_n, accept, ack, data
  - outputs: wren, data register, full flag, eff_full
- The top level contains the request register, the port-index decode, write_blocked, and the optional counter.

## Test plan
- **Reset mid-write:** assert reset_n = 0 in the cycle after a valid request → no wren ever pulses, all outputs 0, stall_count 0.
- **Single write:** write port 2 with 0x123456789 at cycle N → in N+2, wren = 4'b0100 for exactly one cycle, port_data[2] = 0x123456789, port_full[2] = 1. write_blocked stays 0.
- **Write to a full port:** port 1 is full with no ack; write port 1 with 0xAA → write_blocked = 1 in the commit cycle, port_data[1] unchanged, no wren; with the macro defined, stall_count = 1.
- **Simultaneous ack and write:** port 0 is full; port_ack[0] = 1 in the same cycle a write of 0x55 commits → not blocked, wren[0] pulses, port_data[0] = 0x55, port_full[0] stays 1.
- **Out-of-range index:** COUNT = 3, port_addr = 3, valid write → no wren, no write_blocked, no state change.
- **Counter saturation:** STALL_COUNT_WIDTH = 2, five consecutive blocked writes → stall_count reads 1, 2, 3, 3, 3.
